button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end input stage for the player controls: three raw push-buttons (left, right, fire) from board pins, all in the i_clk_25MHz domain.
- Each button is synchronised, debounced, and presented as a clean level plus a one-cycle press pulse.
- Drives the ship position stage (step-per-press via pulse outputs) and the fire/laser logic (pulse outputs).

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clock edges (10 ms at 25 MHz) the synchronised input must hold a new value before it is accepted; legal range >= 2.
- REPEAT_CYCLES, 2500000, auto-repeat pulse period in clocks (100 ms); used only when the optional feature is compiled in.

Ports:
- i_clk_25MHz  input  1  system clock, 25 MHz
- i_reset  input  1  synchronous, active-low reset
- i_left_raw  input  1  raw left button, asynchronous, active-high, may bounce
- i_right_raw  input  1  raw right button, same properties
- i_fire_raw  input  1  raw fire button, same properties
- o_left_level  output  1  debounced left level
- o_right_level  output  1  debounced right level
- o_fire_level  output  1  debounced fire level
- o_left_pulse  output  1  one-cycle pulse on accepted left press
- o_right_pulse  output  1  one-cycle pulse on accepted right press
- o_fire_pulse  output  1  one-cycle pulse on accepted fire press

Behaviour:
- Reset and clocking
  - Reset: synchronous, active-low. The clock is i_clk_25MHz.
  - While i_reset==0: both synchroniser flops = 0, state = RELEASED, counter = 0, every output = 0.
- Synchroniser
  - Each raw input passes through a 2-flop synchroniser; the second flop is s.
  - The FSM samples s only.
- Channels
  - The three channels are identical and fully independent: no arbitration and no priority.
  - Simultaneous left and right presses both assert; the ship stage resolves priority.
- Per-channel FSM (registered outputs)
  - RELEASED: level=0. On s==1 go to PRESS_CHECK, counter=1.
  - PRESS_CHECK: if s==0, return to RELEASED with counter=0 (glitch rejected, no pulse). Otherwise counter++. When counter reaches DEBOUNCE_CYCLES: go to PRESSED, level<=1, pulse<=1, counter=0.
  - PRESSED: level=1. On s==0 go to RELEASE_CHECK, counter=1.
  - RELEASE_CHECK: if s==1, return to PRESSED with counter=0 (no new pulse). Otherwise counter++. At DEBOUNCE_CYCLES: go to RELEASED, level<=0, counter=0.
- Pulse
  - Pulse is high for exactly one cycle: the cycle following the PRESS_CHECK->PRESSED edge.
  - No pulse is ever generated on release.
- Latency
  - Raw input first sampled high at clock edge 0: level and pulse are high after edge DEBOUNCE_CYCLES+1.
  - Release is symmetric: level is low after edge DEBOUNCE_CYCLES+1 from the first raw-low sampling edge.
- Counter
  - Width is clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1).
  - The counter never wraps: it is always cleared on a state change.
- Reset mid-operation
  - Reset during any state returns the channel to RELEASED immediately.
  - A button still held after reset release must requalify through the full debounce, then produces exactly one pulse.
- State encoding: 2-bit; no unreachable encodings. Any illegal value decodes to RELEASED.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter increments every cycle.
  - On reaching REPEAT_CYCLES, pulse<=1 for one cycle and the repeat counter clears.
  - This continues while the button is held, giving pulses spaced exactly REPEAT_CYCLES apart after the initial press pulse.
  - The repeat counter clears on entering PRESSED and whenever leaving PRESSED.
  - RELEASE_CHECK freezes repeats; returning to PRESSED restarts the repeat count from 0.
- Undefined: no repeat logic is synthesised; one pulse per press only.

Decomposition:
- Shared package game_input_pkg holds:
  - state encodings RELEASED=2'd0, PRESS_CHECK=2'd1, PRESSED=2'd2, RELEASE_CHECK=2'd3;
  - default constants DEBOUNCE_CYCLES_DEFAULT and REPEAT_CYCLES_DEFAULT;
  - the CLK_HZ=25000000 constant.
- Sub-module debounce_channel: synchroniser + FSM + counter(s) for one button.
- Top level button_conditioner instantiates debounce_channel three times.

Test Plan:
- Reset: hold i_reset=0 for 3 clocks with all raw inputs=1 -> all six outputs 0 throughout; release reset -> no output changes for 5 edges.
- Clean press (DEBOUNCE_CYCLES=4): i_left_raw 0->1, first sampled at edge 0 -> o_left_level and o_left_pulse high after edge 5; o_left_pulse low after edge 6; o_left_level stays 1.
- Bounce (DEBOUNCE_CYCLES=4): i_fire_raw toggles 1,1,0,1,1,1,1 -> no pulse from the first burst; a single pulse 5 edges after the final rise; exactly 1 pulse total.
- Release (DEBOUNCE_CYCLES=4): after clean press, drop i_right_raw, then a 1-cycle high glitch mid-release -> level stays 1 and no second pulse; final stable low clears the level 5 edges after the last rise->fall.
- Simultaneous (DEBOUNCE_CYCLES=4): left and right rise on the same edge -> both levels and both pulses assert on the same cycle.
- Mid-press reset: assert reset during PRESS_CHECK with the button held, release reset -> outputs 0, then one pulse DEBOUNCE_CYCLES+1 edges after reset release. With AUTOREPEAT_EN, REPEAT_CYCLES=8 and button held -> pulses spaced exactly 8 cycles apart.

Source files
------------

// File: rtl/game_input_pkg.sv
// game_input_pkg
//   Shared definitions for the player-control input stage.
//   Contents:
//     btn_state_t              per-button debounce FSM states (2-bit, all encodings used)
//     CLK_HZ                   system clock frequency (i_clk_25MHz)
//     DEBOUNCE_CYCLES_DEFAULT  10 ms of stable input at 25 MHz
//     REPEAT_CYCLES_DEFAULT    100 ms auto-repeat period at 25 MHz
//     counter_width()          width of a counter able to hold max(a, b)
package game_input_pkg;

    localparam int unsigned CLK_HZ                  = 25_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250_000;
    localparam int unsigned REPEAT_CYCLES_DEFAULT   = 2_500_000;

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } btn_state_t;

    function automatic int unsigned counter_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// debounce_channel
//   One button: 2-flop synchroniser, debounce FSM, shared cycle counter.
//   Optional feature macro: BUTTON_CONDITIONER_AUTOREPEAT_EN
//     defined   -> while held, extra press pulses every REPEAT_CYCLES clocks
//     undefined -> exactly one pulse per accepted press
//   Ports:
//     i_clk_25MHz  system clock
//     i_reset      synchronous, active-low reset
//     i_raw        raw asynchronous button input (active-high, may bounce)
//     o_level      debounced level (registered)
//     o_pulse      one-cycle pulse on accepted press (registered)
module debounce_channel
    import game_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int unsigned CNT_W = counter_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             sync_q1;
    logic             sync_s;
    btn_state_t       state_q;
    btn_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             pulse_d;

    always_ff @(posedge i_clk_25MHz) begin
        if (!i_reset) begin
            sync_q1 <= 1'b0;
            sync_s  <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            o_level <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            sync_q1 <= i_raw;
            sync_s  <= sync_q1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_level <= level_d;
            o_pulse <= pulse_d;
        end
    end

    // The counter is shared: debounce qualification in the CHECK states,
    // auto-repeat timing in PRESSED. Every state change clears or reloads it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = o_level;
        pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                level_d = 1'b0;
                cnt_d   = '0;
                if (sync_s) begin
                    state_d = PRESS_CHECK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHECK: begin
                if (!sync_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    // this edge is the DEBOUNCE_CYCLES-th consecutive high sample
                    state_d = PRESSED;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                level_d = 1'b1;
                if (!sync_s) begin
                    state_d = RELEASE_CHECK;
                    cnt_d   = CNT_ONE;
                end else begin
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    if (cnt_q == RP_LAST) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            RELEASE_CHECK: begin
                if (sync_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = RELEASED;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                level_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Player-control front end: left, right and fire buttons are each
//   synchronised and debounced by an independent debounce_channel.
//   No arbitration between channels; simultaneous presses all assert.
//   Optional feature macro: BUTTON_CONDITIONER_AUTOREPEAT_EN (auto-repeat pulses).
//   Ports:
//     i_clk_25MHz                                system clock, 25 MHz
//     i_reset                                    synchronous, active-low reset
//     i_left_raw / i_right_raw / i_fire_raw      raw buttons (async, active-high)
//     o_left_level / o_right_level / o_fire_level debounced levels
//     o_left_pulse / o_right_pulse / o_fire_pulse one-cycle press pulses
module button_conditioner
    import game_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    input  logic i_left_raw,
    input  logic i_right_raw,
    input  logic i_fire_raw,
    output logic o_left_level,
    output logic o_right_level,
    output logic o_fire_level,
    output logic o_left_pulse,
    output logic o_right_pulse,
    output logic o_fire_pulse
);

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_left (
        .i_clk_25MHz(i_clk_25MHz),
        .i_reset    (i_reset),
        .i_raw      (i_left_raw),
        .o_level    (o_left_level),
        .o_pulse    (o_left_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_right (
        .i_clk_25MHz(i_clk_25MHz),
        .i_reset    (i_reset),
        .i_raw      (i_right_raw),
        .o_level    (o_right_level),
        .o_pulse    (o_right_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_fire (
        .i_clk_25MHz(i_clk_25MHz),
        .i_reset    (i_reset),
        .i_raw      (i_fire_raw),
        .o_level    (o_fire_level),
        .o_pulse    (o_fire_pulse)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed vector table + hand-written corner sequences + randomized
//   stimulus, all outputs also compared every cycle against a run-length
//   reference model. Bit order in 3-bit fields: [2]=left, [1]=right, [0]=fire.
module tb_button_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned RP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic left_raw = 1'b0, right_raw = 1'b0, fire_raw = 1'b0;
    logic left_lvl, right_lvl, fire_lvl, left_pls, right_pls, fire_pls;

    always #20 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .i_clk_25MHz  (clk),
        .i_reset      (rst_n),
        .i_left_raw   (left_raw),
        .i_right_raw  (right_raw),
        .i_fire_raw   (fire_raw),
        .o_left_level (left_lvl),
        .o_right_level(right_lvl),
        .o_fire_level (fire_lvl),
        .o_left_pulse (left_pls),
        .o_right_pulse(right_pls),
        .o_fire_pulse (fire_pls)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] lvls();
        return {left_lvl, right_lvl, fire_lvl};
    endfunction

    function automatic logic [2:0] plss();
        return {left_pls, right_pls, fire_pls};
    endfunction

    // ---------------- reference model ----------------
    // A button's accepted level flips once the synchronised sample has
    // disagreed with it on DB consecutive edges; a press pulse accompanies
    // a flip to 1. With auto-repeat, every RP consecutive agreeing-high
    // edges while accepted high yields another pulse.
    bit          m_s1[3], m_s2[3], m_lvl[3], m_pls[3];
    int unsigned m_run[3], m_rep[3];
    bit          raw_now[3];

    always @(posedge clk) begin
        raw_now[0] = left_raw;
        raw_now[1] = right_raw;
        raw_now[2] = fire_raw;
        for (int c = 0; c < 3; c++) begin
            if (!rst_n) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pls[c] = 0;
                m_run[c] = 0; m_rep[c] = 0;
            end else begin
                m_pls[c] = 0;
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_lvl[c] = m_s2[c];
                        m_pls[c] = m_s2[c];
                        m_run[c] = 0;
                        m_rep[c] = 0;
                    end
                end else if (m_run[c] != 0) begin
                    m_run[c] = 0;
                    m_rep[c] = 0;
                end else if (m_lvl[c]) begin
                    m_rep[c]++;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    if (m_rep[c] == RP) begin
                        m_pls[c] = 1;
                        m_rep[c] = 0;
                    end
`endif
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw_now[c];
            end
        end
    end

    always @(negedge clk) begin
        chk("model_levels", lvls(), {m_lvl[0], m_lvl[1], m_lvl[2]});
        chk("model_pulses", plss(), {m_pls[0], m_pls[1], m_pls[2]});
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0] raw;
        logic [2:0] lvl;
        logic [2:0] pls;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic [2:0] raw, input logic [2:0] lvl,
                       input logic [2:0] pls, input string nm);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.raw = raw; v.lvl = lvl; v.pls = pls; v.nm = nm;
            vecs.push_back(v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_raw(input logic [2:0] r);
        left_raw = r[2]; right_raw = r[1]; fire_raw = r[0];
    endtask

    int unsigned hold[3];
    logic [2:0]  rnd_raw;
    int          rst_left;

    initial begin
        // clean left press / release
        add(5, 3'b100, 3'b000, 3'b000, "press_wait");
        add(1, 3'b100, 3'b100, 3'b100, "press_edge");
        add(2, 3'b100, 3'b100, 3'b000, "press_hold");
        add(5, 3'b000, 3'b100, 3'b000, "release_wait");
        add(3, 3'b000, 3'b000, 3'b000, "release_done");
        // simultaneous left+right
        add(5, 3'b110, 3'b000, 3'b000, "simul_wait");
        add(1, 3'b110, 3'b110, 3'b110, "simul_edge");
        add(1, 3'b110, 3'b110, 3'b000, "simul_hold");
        add(5, 3'b000, 3'b110, 3'b000, "simul_rel_wait");
        add(3, 3'b000, 3'b000, 3'b000, "simul_rel_done");
        // fire bounce 1,1,0,1,1,1,1...
        add(2, 3'b001, 3'b000, 3'b000, "bounce_a");
        add(1, 3'b000, 3'b000, 3'b000, "bounce_gap");
        add(5, 3'b001, 3'b000, 3'b000, "bounce_b");
        add(1, 3'b001, 3'b001, 3'b001, "bounce_edge");
        add(1, 3'b001, 3'b001, 3'b000, "bounce_hold");
        add(5, 3'b000, 3'b001, 3'b000, "bounce_rel_wait");
        add(3, 3'b000, 3'b000, 3'b000, "bounce_rel_done");
        // right press, then release with a one-cycle high glitch
        add(5, 3'b010, 3'b000, 3'b000, "right_wait");
        add(1, 3'b010, 3'b010, 3'b010, "right_edge");
        add(1, 3'b010, 3'b010, 3'b000, "right_hold");
        add(2, 3'b000, 3'b010, 3'b000, "glitch_pre");
        add(1, 3'b010, 3'b010, 3'b000, "glitch_hi");
        add(5, 3'b000, 3'b010, 3'b000, "glitch_post");
        add(2, 3'b000, 3'b000, 3'b000, "glitch_done");

        // reset held with all buttons pressed
        rst_n = 1'b0;
        set_raw(3'b111);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_levels", lvls(), 3'b000);
            chk("reset_pulses", plss(), 3'b000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_levels", lvls(), 3'b000);
            chk("post_reset_pulses", plss(), 3'b000);
        end
        tick();
        chk("post_reset_qual_levels", lvls(), 3'b111);
        chk("post_reset_qual_pulses", plss(), 3'b111);
        set_raw(3'b000);
        for (int i = 0; i < 12; i++) tick();

        foreach (vecs[i]) begin
            set_raw(vecs[i].raw);
            tick();
            chk({vecs[i].nm, "_lvl"}, lvls(), vecs[i].lvl);
            chk({vecs[i].nm, "_pls"}, plss(), vecs[i].pls);
        end

        // reset while left is in press qualification
        set_raw(3'b100);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midreset_lvl", lvls(), 3'b000);
            chk("midreset_pls", plss(), 3'b000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("requal_wait_lvl", lvls(), 3'b000);
            chk("requal_wait_pls", plss(), 3'b000);
        end
        tick();
        chk("requal_edge_lvl", lvls(), 3'b100);
        chk("requal_edge_pls", plss(), 3'b100);
        for (int k = 1; k <= 2 * int'(RP); k++) begin
            tick();
            chk("held_lvl", lvls(), 3'b100);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            chk("repeat_pls", plss(), (k % int'(RP) == 0) ? 3'b100 : 3'b000);
`else
            chk("held_no_repeat_pls", plss(), 3'b000);
`endif
        end
        set_raw(3'b000);
        for (int i = 0; i < 12; i++) tick();

        // randomized bouncing buttons with occasional resets
        for (int c = 0; c < 3; c++) hold[c] = 0;
        rnd_raw  = 3'b000;
        rst_left = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    rnd_raw[c] = ~rnd_raw[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(3, 30);
                end
                hold[c]--;
            end
            if (rst_left > 0) begin
                rst_left--;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_left = $urandom_range(1, 3);
            end
            rst_n = (rst_left == 0);
            set_raw(rnd_raw);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
